// File: rtl/scan_unload.sv
// scan_unload: parallel-to-serial unloader for captured scan words.
// A word offered on cap_data is captured when cap_valid and cap_ready are both
// high. It is then shifted out one bit per accepted transfer on a
// valid/ready serial port, with so_last flagging the final bit of the word.
// frame_cnt counts fully unloaded words and wraps at 16 bits.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   cap_valid  in   word on cap_data is offered
//   cap_data   in   WIDTH-bit word to unload
//   cap_ready  out  block can take a word this cycle
//   so_valid   out  so_data holds a valid bit
//   so_ready   in   downstream accepts the current bit
//   so_data    out  current serial bit
//   so_last    out  current bit is the last bit of the word
//   frame_cnt  out  number of fully unloaded words (wraps)
//
// state | meaning
// IDLE  | waiting for a word, cap_ready high
// SHIFT | presenting bits of the captured word
module scan_unload #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_valid,
  input  logic [WIDTH-1:0] cap_data,
  output logic             cap_ready,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_data,
  output logic             so_last,
  output logic [15:0]      frame_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             capture;
  logic             xfer;

  // Combinational in rst so the block refuses words while held in reset and
  // is ready in the very cycle reset is released.
  assign cap_ready = (state == IDLE) && !rst;

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    xfer     = 1'b0;
    so_valid = 1'b0;
    so_last  = 1'b0;
    so_data  = 1'b0;
    case (state)
      IDLE: begin
        if (cap_valid) begin
          capture  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        so_valid = 1'b1;
        so_last  = (bit_cnt == LAST_IDX);
        // The register shifts the already-sent bit away, so the bit the
        // counter points at always sits at the outgoing end.
        so_data  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        if (so_ready) begin
          xfer = 1'b1;
          if (so_last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (capture) begin
      sreg    <= cap_data;
      bit_cnt <= '0;
    end else if (xfer) begin
      sreg    <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      bit_cnt <= so_last ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (xfer && so_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
